// File: rtl/uart_tx_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_unit_if                                              |
// | Description : Byte/strobe handshake between the debugger and the UART TX.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface uart_tx_unit_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_tx_start;
  logic [DATA_BITS-1:0] i_data;
  logic                 o_tx;
  logic                 o_tx_busy;
  logic                 o_tx_done;

  modport master (
    output i_tx_start,
    output i_data,
    input  o_tx,
    input  o_tx_busy,
    input  o_tx_done
  );

  modport slave (
    input  i_tx_start,
    input  i_data,
    output o_tx,
    output o_tx_busy,
    output o_tx_done
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_unit                                                 |
// | Description : UART transmitter, LSB-first, own 16x baud tick generator.    |
// |               Optional parity bit when UART_PARITY_EN is defined.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_tx_unit #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 19_200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_TICKS = 16,
  parameter int PARITY_ODD = 0
) (
  input  wire logic        clk,
  input  wire logic        rst,
  uart_tx_unit_if.slave    bus
);

  localparam int DIVISOR = CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV_W   = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam int BCNT_W  = $clog2(DATA_BITS) + 1;

  localparam logic [DIV_W-1:0]  c_div_last  = DIV_W'(DIVISOR - 1);
  localparam logic [4:0]        c_bit_last  = 5'd15;
  localparam logic [4:0]        c_stop_last = 5'(STOP_TICKS - 1);
  localparam logic [BCNT_W-1:0] c_data_last = BCNT_W'(DATA_BITS - 1);

  // Elaboration-time guard on configurations the counters cannot represent.
  if ((DIVISOR < 2) || (STOP_TICKS < 1) || (STOP_TICKS > 31) || (DATA_BITS < 2) ||
      (PARITY_ODD < 0) || (PARITY_ODD > 1)) begin : g_bad_cfg
    $error("uart_tx_unit: unsupported parameter combination");
  end

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd4
  } state_t;
`endif

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [4:0]            tcnt_q, tcnt_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef UART_PARITY_EN
  logic                  par_q, par_d;
`endif

  logic                  tick;
  logic                  bit_end;
  logic                  stop_end;
  logic [DATA_BITS-1:0]  shift_nx;

  assign tick     = (div_q == c_div_last);
  assign bit_end  = tick && (tcnt_q == c_bit_last);
  assign stop_end = tick && (tcnt_q == c_stop_last);
  assign shift_nx = shift_q >> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + 1'b1;
    tcnt_d  = tick ? tcnt_q + 5'd1 : tcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UART_PARITY_EN
    par_d   = par_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        div_d  = '0;
        tcnt_d = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        // The done cycle is already IDLE in the register, but a start there is refused.
        if (bus.i_tx_start && !done_q) begin
          state_d = S_START;
          shift_d = bus.i_data;
          bcnt_d  = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
`ifdef UART_PARITY_EN
          par_d   = (^bus.i_data) ^ PARITY_ODD[0];
`endif
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tcnt_d  = '0;
          bcnt_d  = '0;
          tx_d    = shift_q[0];
        end
      end

      S_DATA: begin
        if (bit_end) begin
          tcnt_d  = '0;
          shift_d = shift_nx;
          if (bcnt_q == c_data_last) begin
`ifdef UART_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bcnt_d = bcnt_q + 1'b1;
            tx_d   = shift_nx[0];
          end
        end
      end

`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tcnt_d  = '0;
          tx_d    = 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (stop_end) begin
          state_d = S_IDLE;
          tcnt_d  = '0;
          div_d   = '0;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        div_d   = '0;
        tcnt_d  = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.o_tx      = tx_q;
  assign bus.o_tx_busy = busy_q;
  assign bus.o_tx_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_tx_unit                                              |
// | Description : Directed frame vectors for uart_tx_unit (DIVISOR = 10).      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_tx_unit;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int BIT_CLKS = 160;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * BIT_CLKS;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_unit_if #(.DATA_BITS(8)) bus ();

  uart_tx_unit #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD),
    .DATA_BITS  (8),
    .STOP_TICKS (16),
    .PARITY_ODD (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // line: serial levels in time order, first bit (start) at index NB-1.
  typedef struct {
    logic [7:0]  data;
    logic [10:0] line;
    bit          inject;
  } vec_t;

  // Start in the current cycle N, then follow the frame through N+FRAME+1 (done cycle).
  task automatic run_frame(input logic [7:0] d, input logic [10:0] line, input bit inject,
                           input string tag);
    int         bad_tx;
    int         bad_busy;
    int         dones;
    int         done_at;
    int         k;
    logic [7:0] rx;
    bad_busy = 0;
    dones    = 0;
    done_at  = -1;
    rx       = '0;
    bus.i_data     = d;
    bus.i_tx_start = 1'b1;
    for (int b = 0; b < NB; b++) begin
      bad_tx = 0;
      for (int c = 0; c < BIT_CLKS; c++) begin
        k = b * BIT_CLKS + c + 1;
        tick();
        bus.i_tx_start = inject && (k == 50 || k == 800);
        bus.i_data     = inject ? 8'h3C : ~d;
        if (bus.o_tx !== line[NB-1-b]) bad_tx++;
        if (bus.o_tx_busy !== 1'b1) bad_busy++;
        if (bus.o_tx_done === 1'b1) begin
          dones++;
          done_at = k;
        end
        if (c == BIT_CLKS / 2 && b >= 1 && b <= 8) rx[b-1] = bus.o_tx;
      end
      check($sformatf("%s bit%0d tx mismatch cycles", tag, b), bad_tx, 0);
    end
    tick();
    bus.i_tx_start = 1'b0;
    if (bus.o_tx_done === 1'b1) begin
      dones++;
      done_at = FRAME + 1;
    end
    check($sformatf("%s busy low cycles in frame", tag), bad_busy, 0);
    check($sformatf("%s done pulse count", tag), dones, 1);
    check($sformatf("%s done pulse cycle", tag), done_at, FRAME + 1);
    check($sformatf("%s busy in done cycle", tag), {31'd0, bus.o_tx_busy}, 0);
    check($sformatf("%s tx in done cycle", tag), {31'd0, bus.o_tx}, 1);
    check($sformatf("%s receiver byte", tag), {24'd0, rx}, {24'd0, d});
  endtask

  vec_t vecs[$];

  initial begin
    int bad;
    int dones;

`ifdef UART_PARITY_EN
    vecs.push_back('{8'hA5, 11'b01010010101, 1'b0});
    vecs.push_back('{8'h00, 11'b00000000001, 1'b0});
    vecs.push_back('{8'hFF, 11'b01111111101, 1'b0});
    vecs.push_back('{8'h5A, 11'b00101101001, 1'b1});
    vecs.push_back('{8'h07, 11'b01110000011, 1'b0});
`else
    vecs.push_back('{8'hA5, 11'b00101001011, 1'b0});
    vecs.push_back('{8'h00, 11'b00000000001, 1'b0});
    vecs.push_back('{8'hFF, 11'b00111111111, 1'b0});
    vecs.push_back('{8'h5A, 11'b00010110101, 1'b1});
`endif

    bus.i_tx_start = 1'b0;
    bus.i_data     = 8'h00;

    // Reset and idle line.
    rst = 1'b1;
    repeat (3) tick();
    check("reset tx", {31'd0, bus.o_tx}, 1);
    check("reset busy", {31'd0, bus.o_tx_busy}, 0);
    check("reset done", {31'd0, bus.o_tx_done}, 0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.o_tx !== 1'b1 || bus.o_tx_busy !== 1'b0 || bus.o_tx_done !== 1'b0) bad++;
    end
    check("idle 100 cycles bad", bad, 0);

    // Back-to-back frames, each started one cycle after the previous done pulse.
    foreach (vecs[i]) begin
      if (i != 0) tick();
      run_frame(vecs[i].data, vecs[i].line, vecs[i].inject, $sformatf("vec%0d", i));
    end

    // Start raised in the done cycle must be refused.
    bus.i_data     = 8'h55;
    bus.i_tx_start = 1'b1;
    tick();
    bus.i_tx_start = 1'b0;
    check("start in done cycle busy", {31'd0, bus.o_tx_busy}, 0);
    check("start in done cycle tx", {31'd0, bus.o_tx}, 1);
    tick();
    tick();

    // Reset in the middle of a frame.
    bus.i_data     = 8'h5A;
    bus.i_tx_start = 1'b1;
    for (int k = 1; k <= 700; k++) begin
      tick();
      bus.i_tx_start = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort tx", {31'd0, bus.o_tx}, 1);
    check("abort busy", {31'd0, bus.o_tx_busy}, 0);
    dones = 0;
    bad   = 0;
    for (int i = 0; i < 1800; i++) begin
      tick();
      if (bus.o_tx_done === 1'b1) dones++;
      if (bus.o_tx !== 1'b1) bad++;
    end
    check("abort no done", dones, 0);
    check("abort line idle", bad, 0);

`ifdef UART_PARITY_EN
    run_frame(8'h81, 11'b01000000101, 1'b0, "after abort");
`else
    run_frame(8'h81, 11'b00100000011, 1'b0, "after abort");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
